uart_rx: RTL and testbench

UART receiver: the receive end of the team's UART link, the counterpart of the UART_TOP transmitter. It recovers 8-bit frames from the serial line `RX_IN` using a clock at PRESCALE times the bit rate. Frames carry an optional even/odd parity bit. The block presents each good byte on `P_DATA` with a one-cycle `data_valid` strobe and flags parity or stop-bit errors.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_if.sv | 24 ++
 rtl/uart_rx_sampler.sv | 68 ++++++
 rtl/uart_rx.sv | 146 ++++++++++++++
 tb/tb_uart_rx.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver and transmitter: data width, default
// prescale, parity type constants, FSM state encoding and the parity helper.
package uart_pkg;

  localparam int DATA_WIDTH       = 8;
  localparam int PRESCALE_DEFAULT = 8;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Parity bit a transmitter appends to data for the given parity type
  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data, input logic ptype);
    logic p_s;
    case (ptype)
      EVEN:    p_s = ^data;
      ODD:     p_s = ~^data;
      default: p_s = 1'b0;
    endcase
    return p_s;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial input, frame configuration and result strobes of the UART receiver.
// The receiver connects through the slave modport, its driver through master.
interface uart_rx_if;
  import uart_pkg::*;

  logic                  RX_IN;
  logic                  parity_EN;
  logic                  parity_type;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  parity_error;
  logic                  stop_error;

  modport master (
    output RX_IN, parity_EN, parity_type,
    input  P_DATA, data_valid, parity_error, stop_error
  );

  modport slave (
    input  RX_IN, parity_EN, parity_type,
    output P_DATA, data_valid, parity_error, stop_error
  );

endinterface

// File: rtl/uart_rx_sampler.sv
// Bit-timing for the UART receiver: edge counter, sample-point decode and bit
// decision. Define UART_RX_MAJORITY_EN for a 3-sample majority vote.
module uart_rx_sampler #(
  parameter int PRESCALE = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic rx_in,
  input  logic run,
  output logic bit_end,
  output logic sample_valid,
  output logic sampled_bit
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST_EDGE   = CW'(PRESCALE - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] EARLY_EDGE  = CW'(PRESCALE / 2 - 1);
  localparam logic [CW-1:0] MID_EDGE    = CW'(PRESCALE / 2);
  localparam logic [CW-1:0] DECIDE_EDGE = CW'(PRESCALE / 2 + 1);
`else
  localparam logic [CW-1:0] DECIDE_EDGE = CW'(PRESCALE / 2);
`endif

  logic [CW-1:0] edge_cnt_r;
`ifdef UART_RX_MAJORITY_EN
  logic early_r;
  logic mid_r;
`endif

  // Edge position within the current bit; held at 0 while the line is idle
  always_ff @(posedge CLK) begin
    if (!RST) begin
      edge_cnt_r <= {CW{1'b0}};
    end else if (!run) begin
      edge_cnt_r <= {CW{1'b0}};
    end else if (edge_cnt_r == LAST_EDGE) begin
      edge_cnt_r <= {CW{1'b0}};
    end else begin
      edge_cnt_r <= edge_cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // Capture the two votes that precede the decision edge
  always_ff @(posedge CLK) begin
    if (!RST) begin
      early_r <= 1'b0;
      mid_r   <= 1'b0;
    end else begin
      early_r <= (edge_cnt_r == EARLY_EDGE) ? rx_in : early_r;
      mid_r   <= (edge_cnt_r == MID_EDGE)   ? rx_in : mid_r;
    end
  end
`endif

  // Decode bit end / decision edge and form the bit value
  always_comb begin
    bit_end      = (edge_cnt_r == LAST_EDGE);
    sample_valid = (edge_cnt_r == DECIDE_EDGE);
`ifdef UART_RX_MAJORITY_EN
    sampled_bit  = (early_r & mid_r) | (early_r & rx_in) | (mid_r & rx_in);
`else
    sampled_bit  = rx_in;
`endif
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/parity/stop FSM, shift register, parity check and
// registered result strobes. UART_RX_MAJORITY_EN selects majority sampling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT
) (
  input  logic     CLK,
  input  logic     RST,
  uart_rx_if.slave bus
);

  uart_state_t           state_r;
  logic [2:0]            bit_cnt_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [DATA_WIDTH-1:0] p_data_r;
  logic                  par_en_r;
  logic                  par_type_r;
  logic                  par_err_r;
  logic                  stop_bit_r;
  logic                  data_valid_r;
  logic                  parity_error_r;
  logic                  stop_error_r;

  logic run_s;
  logic glitch_s;
  logic bit_end_s;
  logic sample_valid_s;
  logic sampled_bit_s;

  uart_rx_sampler #(
    .PRESCALE(PRESCALE)
  ) u_sampler (
    .CLK          (CLK),
    .RST          (RST),
    .rx_in        (bus.RX_IN),
    .run          (run_s),
    .bit_end      (bit_end_s),
    .sample_valid (sample_valid_s),
    .sampled_bit  (sampled_bit_s)
  );

  // Bit timing runs from the start edge until the frame ends or a glitch aborts it
  always_comb begin
    run_s    = 1'b1;
    glitch_s = 1'b0;
    if (state_r == IDLE) begin
      run_s = ~bus.RX_IN;
    end else if ((state_r == START) && sample_valid_s && sampled_bit_s) begin
      glitch_s = 1'b1;
      run_s    = 1'b0;
    end else begin
      run_s = 1'b1;
    end
  end

  // Frame FSM with shift register, parity latch and output registers
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r        <= IDLE;
      bit_cnt_r      <= 3'd0;
      shift_r        <= {DATA_WIDTH{1'b0}};
      p_data_r       <= {DATA_WIDTH{1'b0}};
      par_en_r       <= 1'b0;
      par_type_r     <= 1'b0;
      par_err_r      <= 1'b0;
      stop_bit_r     <= 1'b0;
      data_valid_r   <= 1'b0;
      parity_error_r <= 1'b0;
      stop_error_r   <= 1'b0;
    end else begin
      data_valid_r   <= 1'b0;
      parity_error_r <= 1'b0;
      stop_error_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!bus.RX_IN) begin
            state_r    <= START;
            par_en_r   <= bus.parity_EN;
            par_type_r <= bus.parity_type;
            par_err_r  <= 1'b0;
            bit_cnt_r  <= 3'd0;
          end else begin
            state_r <= IDLE;
          end
        end
        START: begin
          if (glitch_s) begin
            state_r <= IDLE;
          end else if (bit_end_s) begin
            state_r <= DATA;
          end else begin
            state_r <= START;
          end
        end
        DATA: begin
          if (sample_valid_s) begin
            shift_r[bit_cnt_r] <= sampled_bit_s;
          end
          if (bit_end_s) begin
            if (bit_cnt_r == 3'd7) begin
              bit_cnt_r <= 3'd0;
              state_r   <= par_en_r ? PARITY : STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end
        end
        PARITY: begin
          if (sample_valid_s && (sampled_bit_s != parity_bit(shift_r, par_type_r))) begin
            par_err_r <= 1'b1;
          end
          if (bit_end_s) begin
            state_r <= STOP;
          end
        end
        STOP: begin
          if (sample_valid_s) begin
            stop_bit_r <= sampled_bit_s;
          end
          // A parity failure outranks a bad stop bit
          if (bit_end_s) begin
            state_r <= IDLE;
            if (par_err_r) begin
              parity_error_r <= 1'b1;
            end else if (!stop_bit_r) begin
              stop_error_r <= 1'b1;
            end else begin
              data_valid_r <= 1'b1;
              p_data_r     <= shift_r;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.P_DATA       = p_data_r;
  assign bus.data_valid   = data_valid_r;
  assign bus.parity_error = parity_error_r;
  assign bus.stop_error   = stop_error_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at PRESCALE=8: directed scenarios plus
// randomized frames checked against a frame-level reference model.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int P = 8;

  typedef struct {
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] pd;
    int         cyc;
  } ev_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] last_good = 8'h00;
  ev_t  ev_q[$];
  ev_t  exp_q[$];

  uart_rx_if bus();

  uart_rx #(.PRESCALE(P)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Record every strobe seen mid-cycle
  always @(negedge CLK) begin
    if (bus.data_valid === 1'b1 || bus.parity_error === 1'b1 || bus.stop_error === 1'b1) begin
      ev_t e;
      e.dv  = bus.data_valid;
      e.pe  = bus.parity_error;
      e.se  = bus.stop_error;
      e.pd  = bus.P_DATA;
      e.cyc = cyc;
      ev_q.push_back(e);
    end
  end

  // Frame-level reference: one outcome per frame, N*P cycles after the start edge
  function automatic ev_t model(input logic [7:0] d, input logic pen, input logic ptype,
                                input logic pbit, input logic stopb, input int s,
                                input logic [7:0] prev);
    ev_t e;
    logic want;
    want  = (($countones(d) % 2) == 1) ^ (ptype == ODD);
    e.dv  = 1'b0;
    e.pe  = 1'b0;
    e.se  = 1'b0;
    e.pd  = prev;
    e.cyc = s + (pen ? 11 : 10) * P;
    if (pen && (pbit != want)) e.pe = 1'b1;
    else if (!stopb) e.se = 1'b1;
    else begin
      e.dv = 1'b1;
      e.pd = d;
    end
    return e;
  endfunction

  task automatic sync();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptype,
                            input logic pbit, input logic stopb);
    ev_t e;
    e = model(d, pen, ptype, pbit, stopb, cyc, last_good);
    last_good = e.pd;
    exp_q.push_back(e);
    bus.parity_EN   = pen;
    bus.parity_type = ptype;
    bus.RX_IN       = 1'b0;
    repeat (P) sync();
    for (int i = 0; i < 8; i++) begin
      bus.RX_IN = d[i];
      repeat (P) sync();
    end
    if (pen) begin
      bus.RX_IN = pbit;
      repeat (P) sync();
    end
    bus.RX_IN = stopb;
    repeat (P) sync();
    bus.RX_IN = 1'b1;
  endtask

  task automatic pop_ev(output ev_t e);
    if (ev_q.size() > 0) begin
      e = ev_q.pop_front();
    end else begin
      e.dv = 1'b0; e.pe = 1'b0; e.se = 1'b0; e.pd = 8'h00; e.cyc = -1;
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    bus.RX_IN = 1'b1;
    bus.parity_EN = 1'b0;
    bus.parity_type = EVEN;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({bus.P_DATA, bus.data_valid, bus.parity_error, bus.stop_error} !== 11'h000) begin
      errors++;
      $display("FAIL reset_state: P_DATA=%h dv=%b pe=%b se=%b, expected all zero",
               bus.P_DATA, bus.data_valid, bus.parity_error, bus.stop_error);
    end
    sync();
    RST = 1'b1;
    repeat (3) sync();
  endtask

  task automatic test_no_parity();
    ev_t exp, act;
    send_frame(8'hA5, 1'b0, EVEN, 1'b0, 1'b1);
    repeat (4) sync();
    exp = exp_q.pop_front();
    pop_ev(act);
    checks++;
    if ({act.dv, act.pe, act.se, act.pd} !== {exp.dv, exp.pe, exp.se, exp.pd}) begin
      errors++;
      $display("FAIL no_parity: dv/pe/se/P_DATA=%b%b%b/%h, expected %b%b%b/%h",
               act.dv, act.pe, act.se, act.pd, exp.dv, exp.pe, exp.se, exp.pd);
    end
    checks++;
    if (act.cyc !== exp.cyc) begin
      errors++;
      $display("FAIL no_parity latency: strobe at %0d, expected %0d", act.cyc, exp.cyc);
    end
  endtask

  task automatic test_parity_good();
    ev_t exp, act;
    send_frame(8'hAA, 1'b1, EVEN, 1'b0, 1'b1);
    repeat (4) sync();
    exp = exp_q.pop_front();
    pop_ev(act);
    checks++;
    if ({act.dv, act.pe, act.se, act.pd} !== {exp.dv, exp.pe, exp.se, exp.pd}) begin
      errors++;
      $display("FAIL parity_good: dv/pe/se/P_DATA=%b%b%b/%h, expected %b%b%b/%h",
               act.dv, act.pe, act.se, act.pd, exp.dv, exp.pe, exp.se, exp.pd);
    end
    checks++;
    if (act.cyc !== exp.cyc) begin
      errors++;
      $display("FAIL parity_good latency: strobe at %0d, expected %0d", act.cyc, exp.cyc);
    end
  endtask

  task automatic test_parity_bad();
    ev_t exp, act;
    send_frame(8'hE4, 1'b1, ODD, 1'b0, 1'b1);
    repeat (4) sync();
    exp = exp_q.pop_front();
    pop_ev(act);
    checks++;
    if ({act.dv, act.pe, act.se, act.pd} !== {exp.dv, exp.pe, exp.se, exp.pd}) begin
      errors++;
      $display("FAIL parity_bad: dv/pe/se/P_DATA=%b%b%b/%h, expected %b%b%b/%h",
               act.dv, act.pe, act.se, act.pd, exp.dv, exp.pe, exp.se, exp.pd);
    end
    checks++;
    if (act.cyc !== exp.cyc) begin
      errors++;
      $display("FAIL parity_bad latency: strobe at %0d, expected %0d", act.cyc, exp.cyc);
    end
    @(negedge CLK);
    checks++;
    if (bus.P_DATA !== 8'hAA) begin
      errors++;
      $display("FAIL parity_bad hold: P_DATA=%h, expected aa", bus.P_DATA);
    end
  endtask

  task automatic test_stop_error();
    ev_t exp, act;
    sync();
    send_frame(8'h3C, 1'b0, EVEN, 1'b0, 1'b0);
    repeat (4) sync();
    exp = exp_q.pop_front();
    pop_ev(act);
    checks++;
    if ({act.dv, act.pe, act.se, act.pd} !== {exp.dv, exp.pe, exp.se, exp.pd}) begin
      errors++;
      $display("FAIL stop_error: dv/pe/se/P_DATA=%b%b%b/%h, expected %b%b%b/%h",
               act.dv, act.pe, act.se, act.pd, exp.dv, exp.pe, exp.se, exp.pd);
    end
    checks++;
    if (act.cyc !== exp.cyc) begin
      errors++;
      $display("FAIL stop_error latency: strobe at %0d, expected %0d", act.cyc, exp.cyc);
    end
  endtask

  task automatic test_glitch();
    ev_t exp, act;
    bus.RX_IN = 1'b0;
    repeat (2) sync();
    bus.RX_IN = 1'b1;
    repeat (20) sync();
    checks++;
    if (ev_q.size() !== 0) begin
      errors++;
      $display("FAIL glitch: %0d strobes after glitch, expected 0", ev_q.size());
      ev_q.delete();
    end
    send_frame(8'h81, 1'b0, EVEN, 1'b0, 1'b1);
    repeat (4) sync();
    exp = exp_q.pop_front();
    pop_ev(act);
    checks++;
    if ({act.dv, act.pd, act.cyc} !== {exp.dv, exp.pd, exp.cyc}) begin
      errors++;
      $display("FAIL glitch_recover: dv=%b P_DATA=%h at %0d, expected dv=%b %h at %0d",
               act.dv, act.pd, act.cyc, exp.dv, exp.pd, exp.cyc);
    end
  endtask

  task automatic test_back_to_back();
    ev_t exp, act;
    send_frame(8'h11, 1'b0, EVEN, 1'b0, 1'b1);
    send_frame(8'hEE, 1'b0, EVEN, 1'b0, 1'b1);
    repeat (4) sync();
    for (int k = 0; k < 2; k++) begin
      exp = exp_q.pop_front();
      pop_ev(act);
      checks++;
      if ({act.dv, act.pe, act.se, act.pd, act.cyc} !== {exp.dv, exp.pe, exp.se, exp.pd, exp.cyc}) begin
        errors++;
        $display("FAIL back_to_back[%0d]: dv/pe/se/P_DATA=%b%b%b/%h at %0d, expected %b%b%b/%h at %0d",
                 k, act.dv, act.pe, act.se, act.pd, act.cyc, exp.dv, exp.pe, exp.se, exp.pd, exp.cyc);
      end
    end
  endtask

  task automatic test_reset_midframe();
    bus.RX_IN = 1'b0;
    repeat (30) sync();
    RST = 1'b0;
    bus.RX_IN = 1'b1;
    sync();
    @(negedge CLK);
    checks++;
    if ({bus.P_DATA, bus.data_valid, bus.parity_error, bus.stop_error} !== 11'h000) begin
      errors++;
      $display("FAIL reset_midframe: P_DATA=%h dv=%b pe=%b se=%b, expected all zero",
               bus.P_DATA, bus.data_valid, bus.parity_error, bus.stop_error);
    end
    sync();
    RST = 1'b1;
    last_good = 8'h00;
    repeat (100) sync();
    checks++;
    if (ev_q.size() !== 0) begin
      errors++;
      $display("FAIL reset_midframe: %0d strobes from aborted frame, expected 0", ev_q.size());
      ev_q.delete();
    end
  endtask

  task automatic test_random();
    ev_t exp, act;
    logic [7:0] d;
    logic pen, ptype, want, pbit, stopb;
    for (int n = 0; n < 12; n++) begin
      d     = 8'($urandom);
      pen   = 1'($urandom);
      ptype = 1'($urandom);
      want  = (($countones(d) % 2) == 1) ^ (ptype == ODD);
      pbit  = want ^ (($urandom % 4) == 0);
      stopb = (($urandom % 4) != 0);
      repeat ($urandom % 3) sync();
      send_frame(d, pen, ptype, pbit, stopb);
    end
    repeat (4) sync();
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      pop_ev(act);
      checks++;
      if ({act.dv, act.pe, act.se, act.pd, act.cyc} !== {exp.dv, exp.pe, exp.se, exp.pd, exp.cyc}) begin
        errors++;
        $display("FAIL random: dv/pe/se/P_DATA=%b%b%b/%h at %0d, expected %b%b%b/%h at %0d",
                 act.dv, act.pe, act.se, act.pd, act.cyc, exp.dv, exp.pe, exp.se, exp.pd, exp.cyc);
      end
    end
    checks++;
    if (ev_q.size() !== 0) begin
      errors++;
      $display("FAIL random: %0d unexpected extra strobes", ev_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_no_parity();
    test_parity_good();
    test_parity_bad();
    test_stop_error();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
